path_delay_meter: RTL and testbench
===================================

Name: path_delay_meter

Overview:
- Measurement stage that drives and observes one spy-path delay chain for delay-based Trojan detection.
- Launches a transition into the chain input, synchronises the chain output, and counts clock cycles until the transition arrives.
- Repeats this for a programmable number of trials and accumulates sum, minimum and maximum.
- Hands the results to the readout logic over a valid/ready handshake.

Parameters:
- CNT_W, 12, width of the per-trial cycle counter, min and max.
- ACC_W, 20, width of the delay sum (covers CNT_W + 8 trial bits).
- TIMEOUT, 4000, cycle limit for MEASURE and for SETTLE; must be less than 2^CNT_W.
- SETTLE_CYC, 4, consecutive stable cycles required before each launch.
- INVERT, 0, set to 1 when the chain output is the inverse of its input.

Ports:
- clk  in  1  system clock, all flops rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low (already decided).
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- num_trials  in  8  trial count, latched on an accepted start; 0 is treated as 1.
- path_launch  out  1  registered drive to the chain input.
- path_capture  in  1  chain output, asynchronous to clk.
- busy  out  1  high from an accepted start until the handshake completes.
- result_valid  out  1  results are held stable while this is high.
- result_ready  in  1  consumer accept.
- delay_sum  out  ACC_W  sum of per-trial counts.
- delay_min  out  CNT_W  smallest per-trial count.
- delay_max  out  CNT_W  largest per-trial count.
- timeout_err  out  1  sticky per run; set if any trial or settle hit TIMEOUT.

Behaviour:
- Reset values: path_launch=0, busy=0, result_valid=0, timeout_err=0, delay_sum=0, delay_min=0, delay_max=0, state=IDLE.
- path_capture passes through a 2-flop synchroniser (sync1, sync2), reset to 0.
- exp = path_launch XOR INVERT.
- IDLE:
  - start=1 latches the trial count and clears the run accumulators (sum=0, min=all-ones, max=0, timeout_err=0).
  - busy goes to 1; next state SETTLE.
- SETTLE:
  - A stable counter increments while sync2==exp and clears otherwise.
  - Reaching SETTLE_CYC goes to LAUNCH.
  - If TIMEOUT total cycles elapse in SETTLE: set timeout_err, skip the remaining trials, go to DONE.
- LAUNCH (1 cycle): toggle path_launch, cnt=0, go to MEASURE.
- MEASURE:
  - Each edge with sync2!=exp, cnt increments.
  - The first edge with sync2==exp records cnt and goes to RECORD.
  - If cnt reaches TIMEOUT while unmatched: record TIMEOUT, set timeout_err, go to RECORD.
- RECORD (1 cycle):
  - sum += cnt; min = min(min,cnt); max = max(max,cnt); trials_left decrements.
  - trials_left==0 goes to DONE; otherwise SETTLE.
- DONE:
  - Copy the run accumulators to the outputs and assert result_valid.
  - Hold everything while result_ready=0.
  - When result_valid&&result_ready: result_valid=0, busy=0, next IDLE.
  - Outputs keep their last values until the next DONE.
- Latency rule:
  - Assume a path whose output flips D clock edges after the launch edge, with D=0 for a combinational path.
  - The recorded count is exactly D+2, which includes the synchroniser.
  - A glitch shorter than a cycle may or may not register; no filtering is done.
- Launch polarity alternates every trial, so rising and falling delays are interleaved, starting with rising after reset.
- A run with a SETTLE abort leaves sum/min/max covering only the completed trials; min stays all-ones if no trial completed.
- The sum cannot overflow with legal parameters (255 × (2^CNT_W − 1) < 2^ACC_W).
- start asserted together with result_ready in DONE is ignored; a new run needs a start in IDLE.
- Reset asserted mid-run returns the block to the reset values immediately, including path_launch=0.

Test Plan:
- Path model is a D=5 registered delay, INVERT=0, num_trials=4 -> delay_sum=28, delay_min=7, delay_max=7, timeout_err=0; path_launch toggles 4 times and ends at 0.
- Combinational path (D=0), num_trials=0 -> exactly one trial; delay_sum=2, delay_min=delay_max=2.
- Path output stuck at 0 after the first settle, TIMEOUT=50, num_trials=3 -> trial 1 records 50 and sets timeout_err; the next SETTLE never matches exp=1, times out after 50 cycles and aborts; DONE shows delay_sum=50, delay_min=delay_max=50.
- Rise delay 3 and fall delay 6, num_trials=2 -> delay_min=5, delay_max=8, delay_sum=13.
- result_ready held low for 20 cycles in DONE, with start pulsed meanwhile -> outputs stable, busy=1, no new run; result_ready=1 -> result_valid=0 and busy=0 on the next cycle.
- rst_n asserted during MEASURE of trial 2 -> all outputs at reset values immediately, including path_launch=0; a fresh start with D=5 again yields count 7 per trial.

Source files
------------

// File: rtl/path_delay_meter.sv
// Spy-path delay meter: launches alternating transitions into a delay chain and
// counts synchronised arrival cycles, accumulating sum/min/max over a run of trials.
module path_delay_meter #(
    parameter int CNT_W      = 12,
    parameter int ACC_W      = 20,
    parameter int TIMEOUT    = 4000,
    parameter int SETTLE_CYC = 4,
    parameter int INVERT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_trials,
    output logic             path_launch,
    input  logic             path_capture,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [ACC_W-1:0] delay_sum,
    output logic [CNT_W-1:0] delay_min,
    output logic [CNT_W-1:0] delay_max,
    output logic             timeout_err
);

    localparam int   STB_W   = $clog2(SETTLE_CYC + 1);
    localparam logic INV_BIT = (INVERT != 0);

    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, MEASURE, RECORD, DONE} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             launch_q, launch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [7:0]       trials_q, trials_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
    logic             terr_q, terr_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] outSum_q, outSum_d;
    logic [CNT_W-1:0] outMin_q, outMin_d, outMax_q, outMax_d;
    logic             expLevel, match;

    // Chain output is asynchronous to clk; its 2-cycle latency is part of every count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= path_capture;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            launch_q <= 1'b0;
            cnt_q    <= '0;
            stable_q <= '0;
            trials_q <= '0;
            sum_q    <= '0;
            min_q    <= '1;
            max_q    <= '0;
            terr_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            outSum_q <= '0;
            outMin_q <= '0;
            outMax_q <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            trials_q <= trials_d;
            sum_q    <= sum_d;
            min_q    <= min_d;
            max_q    <= max_d;
            terr_q   <= terr_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            outSum_q <= outSum_d;
            outMin_q <= outMin_d;
            outMax_q <= outMax_d;
        end
    end

    assign expLevel = launch_q ^ INV_BIT;
    assign match    = (sync2_q == expLevel);

    always_comb begin
        state_d  = state_q;
        launch_d = launch_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        trials_d = trials_q;
        sum_d    = sum_q;
        min_d    = min_q;
        max_d    = max_q;
        terr_d   = terr_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        outSum_d = outSum_q;
        outMin_d = outMin_q;
        outMax_d = outMax_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    trials_d = (num_trials == 8'd0) ? 8'd1 : num_trials;
                    sum_d    = '0;
                    min_d    = '1;
                    max_d    = '0;
                    terr_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = SETTLE;
                end
            end
            // cnt_q doubles as the settle watchdog so a stuck chain cannot hang the run.
            SETTLE: begin
                stable_d = match ? stable_q + STB_W'(1) : '0;
                if (match && stable_q == STB_W'(SETTLE_CYC - 1)) begin
                    state_d = LAUNCH;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LAUNCH: begin
                launch_d = ~launch_q;
                cnt_d    = '0;
                state_d  = MEASURE;
            end
            MEASURE: begin
                if (match) begin
                    state_d = RECORD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d   = CNT_W'(TIMEOUT);
                    terr_d  = 1'b1;
                    state_d = RECORD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECORD: begin
                sum_d    = sum_q + ACC_W'(cnt_q);
                min_d    = (cnt_q < min_q) ? cnt_q : min_q;
                max_d    = (cnt_q > max_q) ? cnt_q : max_q;
                trials_d = trials_q - 8'd1;
                if (trials_q == 8'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Results are published once, on entry to DONE, and then held.
        if (state_d == DONE && state_q != DONE) begin
            valid_d  = 1'b1;
            outSum_d = sum_d;
            outMin_d = min_d;
            outMax_d = max_d;
        end
    end

    assign path_launch  = launch_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign delay_sum    = outSum_q;
    assign delay_min    = outMin_q;
    assign delay_max    = outMax_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter with a tapped delay-line model of the spy path
// (separate rise/fall tap depths, optional stuck-at-0).
module tb_path_delay_meter;

    localparam int CNT_W   = 12;
    localparam int ACC_W   = 20;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       num_trials = 8'd0;
    logic             path_launch;
    logic             path_capture;
    logic             busy;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [ACC_W-1:0] delay_sum;
    logic [CNT_W-1:0] delay_min;
    logic [CNT_W-1:0] delay_max;
    logic             timeout_err;

    int errors = 0;
    int checks = 0;

    path_delay_meter #(
        .CNT_W(CNT_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT), .SETTLE_CYC(4), .INVERT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_trials(num_trials),
        .path_launch(path_launch), .path_capture(path_capture), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .delay_sum(delay_sum), .delay_min(delay_min), .delay_max(delay_max),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Path model: OR of two delayed taps gives rise delay = riseD, fall delay = fallD (fallD >= riseD).
    logic [15:0] hist = '0;
    int          riseD = 5;
    int          fallD = 5;
    logic        stuckLow = 1'b0;

    always @(posedge clk) hist <= {hist[14:0], path_launch};

    function automatic logic tap(input int d, input logic cur, input logic [15:0] h);
        return (d == 0) ? cur : h[d-1];
    endfunction

    assign path_capture = stuckLow ? 1'b0 :
                          (tap(riseD, path_launch, hist) | tap(fallD, path_launch, hist));

    int   toggles = 0;
    logic lastLaunch = 1'b0;
    always @(negedge clk) begin
        if (path_launch !== lastLaunch) toggles = toggles + 1;
        lastLaunch = path_launch;
    end

    typedef struct {
        int         rD;
        int         fD;
        logic       stuck;
        logic [7:0] trials;
        int         expSum;
        int         expMin;
        int         expMax;
        logic       expTerr;
        int         expToggles;
        logic       expLaunch;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int rD, input int fD, input logic stuck, input logic [7:0] trials);
        @(negedge clk);
        riseD      = rD;
        fallD      = fD;
        stuckLow   = stuck;
        num_trials = trials;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitValid();
        int n;
        n = 0;
        while (!result_valid && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("validArrived", 32'(result_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checkOutput("validAfterAccept", 32'(result_valid), 32'd0);
        checkOutput("busyAfterAccept", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_launch"}, 32'(path_launch), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(result_valid), 32'd0);
        checkOutput({tag, "_terr"}, 32'(timeout_err), 32'd0);
        checkOutput({tag, "_sum"}, 32'(delay_sum), 32'd0);
        checkOutput({tag, "_min"}, 32'(delay_min), 32'd0);
        checkOutput({tag, "_max"}, 32'(delay_max), 32'd0);
    endtask

    initial begin
        int snap;
        int n;

        // Order matters: launch polarity carries over between runs.
        vecs[0] = '{5, 5, 1'b0, 8'd4, 28, 7, 7, 1'b0, 4, 1'b0};
        vecs[1] = '{5, 5, 1'b1, 8'd3, 50, 50, 50, 1'b1, 1, 1'b1};
        vecs[2] = '{0, 0, 1'b0, 8'd0, 2, 2, 2, 1'b0, 1, 1'b0};
        vecs[3] = '{3, 6, 1'b0, 8'd2, 13, 5, 8, 1'b0, 2, 1'b0};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            snap = toggles;
            applyStimulus(vecs[i].rD, vecs[i].fD, vecs[i].stuck, vecs[i].trials);
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            waitValid();
            checkOutput($sformatf("v%0d_sum", i), 32'(delay_sum), 32'(vecs[i].expSum));
            checkOutput($sformatf("v%0d_min", i), 32'(delay_min), 32'(vecs[i].expMin));
            checkOutput($sformatf("v%0d_max", i), 32'(delay_max), 32'(vecs[i].expMax));
            checkOutput($sformatf("v%0d_terr", i), 32'(timeout_err), 32'(vecs[i].expTerr));
            checkOutput($sformatf("v%0d_toggles", i), 32'(toggles - snap), 32'(vecs[i].expToggles));
            checkOutput($sformatf("v%0d_launch", i), 32'(path_launch), 32'(vecs[i].expLaunch));
            handshake();
            stuckLow = 1'b0;
            repeat (10) @(negedge clk);
        end

        // Backpressure in DONE with a start pulse that must be ignored.
        applyStimulus(5, 5, 1'b0, 8'd1);
        waitValid();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = (c == 5);
            checkOutput("holdSum", 32'(delay_sum), 32'd7);
            checkOutput("holdBusy", 32'(busy), 32'd1);
            checkOutput("holdValid", 32'(result_valid), 32'd1);
        end
        start = 1'b0;
        handshake();
        repeat (5) @(negedge clk);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleSumKept", 32'(delay_sum), 32'd7);
        checkOutput("idleLaunch", 32'(path_launch), 32'd1);

        // Reset during MEASURE of trial 2, then a clean run.
        snap = toggles;
        applyStimulus(5, 5, 1'b0, 8'd2);
        n = 0;
        while ((toggles - snap) < 2 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("secondLaunchSeen", 32'(toggles - snap), 32'd2);
        repeat (3) @(negedge clk);
        checkOutput("launchBeforeReset", 32'(path_launch), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(5, 5, 1'b0, 8'd2);
        waitValid();
        checkOutput("postReset_sum", 32'(delay_sum), 32'd14);
        checkOutput("postReset_min", 32'(delay_min), 32'd7);
        checkOutput("postReset_max", 32'(delay_max), 32'd7);
        checkOutput("postReset_terr", 32'(timeout_err), 32'd0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
